// File: rtl/stage_ifetch_pkg.sv
// Shared constants for the fetch stage: opcode byte values, halt byte, FSM encodings.
// Also consumed by the decode stage's copy of the opcode classifier.
package stage_ifetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [7:0] HALT_BYTE = 8'h00;
  localparam logic [7:0] OP_INC_P  = 8'h3E;
  localparam logic [7:0] OP_DEC_P  = 8'h3C;
  localparam logic [7:0] OP_INC_D  = 8'h2B;
  localparam logic [7:0] OP_DEC_D  = 8'h2D;
  localparam logic [7:0] OP_OUT    = 8'h2E;
  localparam logic [7:0] OP_IN     = 8'h2C;
  localparam logic [7:0] OP_LOOP_B = 8'h5B;
  localparam logic [7:0] OP_LOOP_E = 8'h5D;

  function automatic logic is_opcode_byte(input logic [7:0] b);
    case (b)
      OP_INC_P, OP_DEC_P, OP_INC_D, OP_DEC_D,
      OP_OUT, OP_IN, OP_LOOP_B, OP_LOOP_E: is_opcode_byte = 1'b1;
      default:                             is_opcode_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_ifetch_classifier.sv
// Combinational byte classifier: flags the eight opcode bytes and the halt byte.
// Used by the fetch stage when STAGE_IFETCH_FILTER_EN is defined; decode may reuse it.
module fetch_opcode_classifier
  import stage_ifetch_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_op,
  output logic       is_halt
);

  assign is_op   = is_opcode_byte(data);
  assign is_halt = (data == HALT_BYTE);

endmodule

// File: rtl/stage_ifetch.sv
// Instruction fetch stage: one byte per instruction, presented on opcode/drdy until ack.
// Optional build macro STAGE_IFETCH_FILTER_EN skips non-opcode bytes instead of presenting them.
module stage_ifetch
  import stage_ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_data,
  output logic [7:0]            opcode,
  output logic                  drdy,
  input  logic                  ack,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  halted,
  output logic [1:0]            state_dbg
);

  // Handshake: opcode is valid while drdy is high and stays frozen until ack;
  // a transfer is drdy && ack. A jump in the same cycle wins and the consumer squashes it.

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  state_t state;
  logic   byte_halt;
  logic   byte_keep;

`ifdef STAGE_IFETCH_FILTER_EN
  logic is_op;
  logic is_halt;

  fetch_opcode_classifier u_classifier (
    .data    (imem_data),
    .is_op   (is_op),
    .is_halt (is_halt)
  );

  assign byte_halt = is_halt;
  assign byte_keep = is_op;
`else
  assign byte_halt = (imem_data == HALT_BYTE);
  assign byte_keep = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_ISSUE;
      pc     <= '0;
      opcode <= '0;
      drdy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (jump) pc <= jump_target;
          else      state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A jump discards the read that is landing this cycle.
          if (jump) begin
            pc    <= jump_target;
            state <= ST_ISSUE;
          end else if (byte_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (byte_keep) begin
            opcode <= imem_data;
            drdy   <= 1'b1;
            state  <= ST_PRESENT;
          end else begin
            pc    <= pc + PC_ONE;
            state <= ST_ISSUE;
          end
        end
        ST_PRESENT: begin
          if (jump) begin
            pc    <= jump_target;
            drdy  <= 1'b0;
            state <= ST_ISSUE;
          end else if (ack) begin
            pc    <= pc + PC_ONE;
            drdy  <= 1'b0;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign imem_en   = (state == ST_ISSUE);
  assign imem_addr = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_stage_ifetch.sv
// Directed bench for stage_ifetch: linear fetch, filter/non-filter sequence, backpressure,
// jump over ack, asynchronous reset, and pc wrap on a 4-bit instance.
module tb_stage_ifetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [7:0]  imem_data = 8'h00;
  logic [7:0]  opcode;
  logic        drdy;
  logic        ack = 1'b0;
  logic [15:0] pc;
  logic        jump = 1'b0;
  logic [15:0] jump_target = '0;
  logic        halted;
  logic [1:0]  state_dbg;

  logic        reset_w = 1'b1;
  logic        imem_en_w;
  logic [3:0]  imem_addr_w;
  logic [7:0]  imem_data_w = 8'h00;
  logic [7:0]  opcode_w;
  logic        drdy_w;
  logic        ack_w = 1'b0;
  logic [3:0]  pc_w;
  logic        jump_w = 1'b0;
  logic [3:0]  jump_target_w = '0;
  logic        halted_w;
  logic [1:0]  state_dbg_w;

  logic [7:0]  mem [0:255];
  logic [7:0]  exp_q [$];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  stage_ifetch #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .opcode(opcode), .drdy(drdy), .ack(ack), .pc(pc),
    .jump(jump), .jump_target(jump_target), .halted(halted), .state_dbg(state_dbg)
  );

  stage_ifetch #(.ADDR_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .opcode(opcode_w), .drdy(drdy_w), .ack(ack_w), .pc(pc_w),
    .jump(jump_w), .jump_target(jump_target_w), .halted(halted_w), .state_dbg(state_dbg_w)
  );

  // Synchronous instruction memories: data one cycle after the strobe.
  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr[7:0]];
  always @(posedge clk) if (imem_en_w) imem_data_w <= 8'h3E;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted opcode (not squashed by jump) must match the queue head.
  always @(negedge clk) begin
    if (!reset && drdy) begin
      check("drdy_nonzero", {31'd0, opcode != 8'h00}, 32'd1);
      if (ack && !jump) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL xfer_unexpected: observed %0h expected none", opcode);
        end else begin
          check("xfer_opcode", {24'd0, opcode}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
  endtask

  // Leaves the bench in cycle 0 (first cycle after release).
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drdy(input string tag, input int budget);
    int n = 0;
    while (!drdy && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, drdy}, 32'd1);
  endtask

  int          pres_cyc [3];
  logic [7:0]  pres_op  [3];
  int          n_pres;
  int          halt_cyc;
  int          k;
  logic        exp_drdy;

  initial begin
    // Reset values.
    load(8'h3E, 8'h2B, 8'h2E, 8'h00);
    tick();
    check("rst_drdy", {31'd0, drdy}, 32'd0);
    check("rst_opcode", {24'd0, opcode}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_imem_en", {31'd0, imem_en}, 32'd1);
    check("rst_imem_addr", {16'd0, imem_addr}, 32'd0);

    // Linear fetch with ack tied high.
    ack = 1'b1;
    exp_q.push_back(8'h3E); exp_q.push_back(8'h2B); exp_q.push_back(8'h2E);
    reset = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      exp_drdy = (c == 2 || c == 5 || c == 8);
      check($sformatf("lin_drdy_c%0d", c), {31'd0, drdy}, {31'd0, exp_drdy});
      if (c == 11) begin
        check("lin_halted", {31'd0, halted}, 32'd1);
        check("lin_halt_imem_en", {31'd0, imem_en}, 32'd0);
      end else begin
        tick();
      end
    end
    // Jump is ignored once halted.
    jump = 1'b1; jump_target = 16'h0005;
    tick();
    jump = 1'b0;
    tick();
    check("halt_jump_pc", {16'd0, pc}, 32'd3);
    check("halt_jump_halted", {31'd0, halted}, 32'd1);

    // Mixed bytes: filter build presents only the opcode byte.
    load(8'h41, 8'h0A, 8'h3C, 8'h00);
`ifdef STAGE_IFETCH_FILTER_EN
    n_pres = 1; pres_cyc[0] = 6; pres_op[0] = 8'h3C; halt_cyc = 9;
`else
    n_pres = 3; halt_cyc = 11;
    pres_cyc[0] = 2; pres_op[0] = 8'h41;
    pres_cyc[1] = 5; pres_op[1] = 8'h0A;
    pres_cyc[2] = 8; pres_op[2] = 8'h3C;
`endif
    for (int i = 0; i < n_pres; i++) exp_q.push_back(pres_op[i]);
    do_reset();
    k = 0;
    for (int c = 0; c <= halt_cyc; c++) begin
      exp_drdy = (k < n_pres) && (c == pres_cyc[k]);
      check($sformatf("mix_drdy_c%0d", c), {31'd0, drdy}, {31'd0, exp_drdy});
      if (exp_drdy) begin
        check("mix_opcode", {24'd0, opcode}, {24'd0, pres_op[k]});
        k++;
      end
      if (c == halt_cyc) check("mix_halted", {31'd0, halted}, 32'd1);
      else tick();
    end

    // Backpressure: byte 2D held for 5 cycles without ack.
    ack = 1'b0;
    load(8'h2D, 8'h3C, 8'h2B, 8'h2E);
    mem[4] = 8'h5B; mem[16] = 8'h2C;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_drdy", {31'd0, drdy}, 32'd1);
      check("bp_opcode", {24'd0, opcode}, 32'h2D);
      check("bp_pc", {16'd0, pc}, 32'd0);
      tick();
    end
    exp_q.push_back(8'h2D);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("bp_pc_adv", {16'd0, pc}, 32'd1);
    check("bp_drdy_drop", {31'd0, drdy}, 32'd0);

    // Walk to pc=4, then jump in the same cycle as ack.
    for (int i = 0; i < 3; i++) begin
      wait_drdy("walk_drdy", 10);
      exp_q.push_back(opcode == 8'h00 ? 8'hFF : mem[pc[7:0]]);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    wait_drdy("jmp_pre_drdy", 10);
    check("jmp_pre_pc", {16'd0, pc}, 32'h4);
    check("jmp_pre_opcode", {24'd0, opcode}, 32'h5B);
    ack = 1'b1; jump = 1'b1; jump_target = 16'h0010;
    tick();
    ack = 1'b0; jump = 1'b0;
    check("jmp_pc", {16'd0, pc}, 32'h10);
    check("jmp_imem_addr", {16'd0, imem_addr}, 32'h10);
    check("jmp_imem_en", {31'd0, imem_en}, 32'd1);
    check("jmp_drdy_j1", {31'd0, drdy}, 32'd0);
    tick();
    check("jmp_drdy_j2", {31'd0, drdy}, 32'd0);
    tick();
    check("jmp_drdy_j3", {31'd0, drdy}, 32'd1);
    check("jmp_opcode_j3", {24'd0, opcode}, 32'h2C);

    // Asynchronous reset in the middle of PRESENT.
    #2 reset = 1'b1;
    #1;
    check("arst_drdy", {31'd0, drdy}, 32'd0);
    check("arst_opcode", {24'd0, opcode}, 32'd0);
    check("arst_pc", {16'd0, pc}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("arst_imem_addr", {16'd0, imem_addr}, 32'd0);
    check("arst_imem_en", {31'd0, imem_en}, 32'd1);
    tick();
    tick();
    check("arst_restart_drdy", {31'd0, drdy}, 32'd1);
    check("arst_restart_opcode", {24'd0, opcode}, 32'h2D);

    // Wrap-around on the 4-bit instance.
    reset_w = 1'b0;
    jump_w = 1'b1; jump_target_w = 4'hF;
    tick();
    jump_w = 1'b0;
    check("wrap_jump_pc", {28'd0, pc_w}, 32'hF);
    k = 0;
    while (!drdy_w && k < 10) begin
      tick();
      k++;
    end
    check("wrap_drdy", {31'd0, drdy_w}, 32'd1);
    check("wrap_opcode", {24'd0, opcode_w}, 32'h3E);
    ack_w = 1'b1;
    tick();
    ack_w = 1'b0;
    check("wrap_pc", {28'd0, pc_w}, 32'd0);
    check("wrap_imem_addr", {28'd0, imem_addr_w}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
